// File: rtl/sm_clk_divider_mc.sv
// -----------------------------------------------------------------------------
// sm_clk_divider_mc
//
// Multi-channel programmable clock divider. From one source clock it produces
// CHANNELS independent divided clocks plus a one-cycle tick in the last cycle
// of each divided period. Each channel's period P is programmable at run time
// through a valid/ready config port. A new period is held in a per-channel
// shadow register and takes effect at the end of the current period, so the
// divided clock never emits a runt pulse.
//
// Channel behaviour:
//   P >= 2 : active, high phase floor(P/2) cycles, low phase ceil(P/2) cycles.
//   P <  2 : channel off, clkOut = 0, tickOut = 0, counter parked at 0.
//
// Optional feature (compile-time macro SM_CLK_DIVIDER_SYNC_EN):
//   Adds input syncIn. On an enabled edge with syncIn = 1, every channel
//   applies its pending update and restarts its period, phase-aligning all
//   channels. Without the macro the port does not exist.
//
// Parameters:
//   CHANNELS     number of output channels (1..16)
//   DIV_W        width of the per-channel period register
//   DEFAULT_DIV  period loaded into every channel at reset
//
// Ports:
//   clkIn       in   source clock
//   rst_p       in   asynchronous active-high reset
//   clkEnable   in   global count enable; low freezes all active channels
//   cfgValid    in   config write request
//   cfgReady    out  config write can be accepted (no update pending on target)
//   cfgChannel  in   target channel of the write
//   cfgDivide   in   new period P for the target channel
//   clkOut      out  divided clocks, registered
//   tickOut     out  one-cycle pulse in the last cycle of each period, registered
//   syncIn      in   phase-align strobe (only with SM_CLK_DIVIDER_SYNC_EN)
// -----------------------------------------------------------------------------
module sm_clk_divider_mc #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2,
  localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clkIn,
  input  logic                rst_p,
  input  logic                clkEnable,
  input  logic                cfgValid,
  output logic                cfgReady,
  input  logic [CH_W-1:0]     cfgChannel,
  input  logic [DIV_W-1:0]    cfgDivide,
  output logic [CHANNELS-1:0] clkOut,
  output logic [CHANNELS-1:0] tickOut
`ifdef SM_CLK_DIVIDER_SYNC_EN
  ,
  input  logic                syncIn
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]    cntQ    [CHANNELS];
  logic [DIV_W-1:0]    cntD    [CHANNELS];
  logic [DIV_W-1:0]    perQ    [CHANNELS];
  logic [DIV_W-1:0]    perD    [CHANNELS];
  logic [DIV_W-1:0]    shadowQ [CHANNELS];
  logic [DIV_W-1:0]    shadowD [CHANNELS];
  logic [CHANNELS-1:0] pendingQ;
  logic [CHANNELS-1:0] pendingD;
  logic [CHANNELS-1:0] clkD;
  logic [CHANNELS-1:0] tickD;

  // Per-channel helpers derived from the current state
  logic [CHANNELS-1:0] chActive;
  logic [CHANNELS-1:0] chWrap;
  logic [CHANNELS-1:0] shadowOn;
  logic [DIV_W-1:0]    cntInc  [CHANNELS];
  logic [DIV_W-1:0]    lastCnt [CHANNELS];
  logic [DIV_W-1:0]    halfPer [CHANNELS];

  // Config write decode
  logic [CHANNELS-1:0] chSelect;
  logic [CHANNELS-1:0] accept;

  // Phase-align strobe, qualified by the global enable
  logic                syncHit;

`ifdef SM_CLK_DIVIDER_SYNC_EN
  assign syncHit = syncIn & clkEnable;
`else
  assign syncHit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Config handshake
  // ---------------------------------------------------------------------------
  // Channel numbers beyond CHANNELS match no select bit: they see cfgReady = 1
  // and the write is silently dropped.
  always_comb begin
    chSelect = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      chSelect[c] = (cfgChannel == CH_W'(c));
    end
  end

  always_comb begin
    cfgReady = 1'b1;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (chSelect[c]) begin
        cfgReady = ~pendingQ[c];
      end
    end
  end

  assign accept = chSelect & {CHANNELS{cfgValid & cfgReady}};

  // ---------------------------------------------------------------------------
  // Per-channel helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      chActive[c] = (perQ[c] >= DIV_W'(2));
      lastCnt[c]  = perQ[c] - DIV_W'(1);
      halfPer[c]  = perQ[c] >> 1;
      cntInc[c]   = cntQ[c] + DIV_W'(1);
      chWrap[c]   = (cntQ[c] == lastCnt[c]);
      shadowOn[c] = (shadowQ[c] >= DIV_W'(2));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      // Default: hold everything, tick drops
      cntD[c]     = cntQ[c];
      perD[c]     = perQ[c];
      shadowD[c]  = shadowQ[c];
      pendingD[c] = pendingQ[c];
      clkD[c]     = clkOut[c];
      tickD[c]    = 1'b0;

      if (syncHit) begin
        // Restart every channel at the top of its high phase, taking any
        // pending period first.
        cntD[c] = '0;
        if (pendingQ[c]) begin
          perD[c]     = shadowQ[c];
          pendingD[c] = 1'b0;
          clkD[c]     = shadowOn[c];
        end else begin
          clkD[c]     = chActive[c];
        end
      end else if (!chActive[c]) begin
        // Off channel: parked, and a pending update lands immediately,
        // independent of clkEnable.
        cntD[c] = '0;
        clkD[c] = 1'b0;
        if (pendingQ[c]) begin
          perD[c]     = shadowQ[c];
          pendingD[c] = 1'b0;
          clkD[c]     = shadowOn[c];
        end
      end else if (clkEnable) begin
        if (chWrap[c]) begin
          // End of period: counter restarts and the high phase begins. A
          // pending period swaps in exactly here so the new waveform starts
          // with a full high phase.
          cntD[c] = '0;
          if (pendingQ[c]) begin
            perD[c]     = shadowQ[c];
            pendingD[c] = 1'b0;
            clkD[c]     = shadowOn[c];
          end else begin
            clkD[c]     = 1'b1;
          end
        end else begin
          cntD[c]  = cntInc[c];
          clkD[c]  = (cntInc[c] < halfPer[c]);
          tickD[c] = (cntInc[c] == lastCnt[c]);
        end
      end

      // Accept can only happen with pendingQ clear, so it never races with an
      // apply on the same channel.
      if (accept[c]) begin
        shadowD[c]  = cfgDivide;
        pendingD[c] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkIn or posedge rst_p) begin
    if (rst_p) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        cntQ[c]    <= '0;
        perQ[c]    <= DIV_W'(DEFAULT_DIV);
        shadowQ[c] <= '0;
      end
      pendingQ <= '0;
      clkOut   <= '0;
      tickOut  <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        cntQ[c]    <= cntD[c];
        perQ[c]    <= perD[c];
        shadowQ[c] <= shadowD[c];
      end
      pendingQ <= pendingD;
      clkOut   <= clkD;
      tickOut  <= tickD;
    end
  end

endmodule

// File: tb/tb_sm_clk_divider_mc.sv
// -----------------------------------------------------------------------------
// tb_sm_clk_divider_mc
//
// Scoreboard bench for sm_clk_divider_mc. The driver issues one set of inputs
// per cycle, advances a behavioural model of every channel (period, position
// within the period, pending shadow value) and queues the expected clkOut /
// tickOut for that edge. An independent monitor pops and compares after every
// rising edge. Directed sequences cover the main scenarios, then randomized
// traffic runs against the same model. Build with SM_CLK_DIVIDER_SYNC_EN to
// also exercise syncIn.
// -----------------------------------------------------------------------------
module tb_sm_clk_divider_mc;

  localparam int CH = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          clkEnable;
  logic          cfgValid;
  logic          cfgReady;
  logic [1:0]    cfgChannel;
  logic [DW-1:0] cfgDivide;
  logic [CH-1:0] clkOut;
  logic [CH-1:0] tickOut;
`ifdef SM_CLK_DIVIDER_SYNC_EN
  logic          syncIn;
`endif

  sm_clk_divider_mc #(
    .CHANNELS   (CH),
    .DIV_W      (DW),
    .DEFAULT_DIV(2)
  ) dut (
    .clkIn     (clk),
    .rst_p     (rst),
    .clkEnable (clkEnable),
    .cfgValid  (cfgValid),
    .cfgReady  (cfgReady),
    .cfgChannel(cfgChannel),
    .cfgDivide (cfgDivide),
    .clkOut    (clkOut),
    .tickOut   (tickOut)
`ifdef SM_CLK_DIVIDER_SYNC_EN
    ,
    .syncIn    (syncIn)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: each channel is a period length plus a position inside
  // the current period; the waveform is high for the first P/2 positions.
  // ---------------------------------------------------------------------------
  int            per    [CH];
  int            shadow [CH];
  bit            pend   [CH];
  int            phase  [CH];
  logic [CH-1:0] mClk;
  logic [CH-1:0] mTick;

  logic [2*CH-1:0] expQ [$];

  task automatic modelReset();
    for (int i = 0; i < CH; i++) begin
      per[i]    = 2;
      shadow[i] = 0;
      pend[i]   = 1'b0;
      phase[i]  = 0;
    end
    mClk  = '0;
    mTick = '0;
  endtask

  task automatic modelStep(input bit en, input bit v, input int ch, input int div, input bit sy);
    bit acc;
    acc = v && (ch < CH) && !pend[ch];
    for (int i = 0; i < CH; i++) begin
      mTick[i] = 1'b0;
      if (sy && en) begin
        if (pend[i]) begin
          per[i]  = shadow[i];
          pend[i] = 1'b0;
        end
        phase[i] = 0;
        mClk[i]  = (per[i] >= 2);
      end else if (per[i] < 2) begin
        phase[i] = 0;
        mClk[i]  = 1'b0;
        if (pend[i]) begin
          per[i]  = shadow[i];
          pend[i] = 1'b0;
          mClk[i] = (per[i] >= 2);
        end
      end else if (en) begin
        if (phase[i] == per[i] - 1 && pend[i]) begin
          per[i]   = shadow[i];
          pend[i]  = 1'b0;
          phase[i] = 0;
          mClk[i]  = (per[i] >= 2);
        end else begin
          phase[i] = (phase[i] + 1) % per[i];
          mClk[i]  = (phase[i] < per[i] / 2);
          mTick[i] = (phase[i] == per[i] - 1);
        end
      end
    end
    if (acc) begin
      shadow[ch] = div;
      pend[ch]   = 1'b1;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input bit en, input bit v, input int ch, input int div, input bit sy);
    logic expReady;
    clkEnable  = en;
    cfgValid   = v;
    cfgChannel = ch[1:0];
    cfgDivide  = div[DW-1:0];
`ifdef SM_CLK_DIVIDER_SYNC_EN
    syncIn     = sy;
`endif
    #1;
    expReady = (ch < CH) ? !pend[ch] : 1'b1;
    check("cfgReady", {31'b0, cfgReady}, {31'b0, expReady});
    modelStep(en, v, ch, div, sy);
    expQ.push_back({mClk, mTick});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  // Write once the target has no pending update; bounded wait.
  task automatic writeWait(input int ch, input int div);
    int tries;
    tries = 0;
    while (pend[ch] && tries < 64) begin
      drive(1'b1, 1'b0, 0, 0, 1'b0);
      tries++;
    end
    check("writeWait", {31'b0, (tries < 64)}, 32'd1);
    drive(1'b1, 1'b1, ch, div, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; returns at a falling edge.
  task automatic midReset();
    rst      = 1'b1;
    cfgValid = 1'b0;
    #1;
    check("resetClk", {28'b0, clkOut}, 32'd0);
    check("resetTick", {28'b0, tickOut}, 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [2*CH-1:0] monExp;

  always @(posedge clk) begin
    #2;
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      check("clkOut", {28'b0, clkOut}, {28'b0, monExp[2*CH-1:CH]});
      check("tickOut", {28'b0, tickOut}, {28'b0, monExp[CH-1:0]});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit en;
    bit v;
    bit sy;
    int ch;
    int div;

    rst        = 1'b1;
    clkEnable  = 1'b0;
    cfgValid   = 1'b0;
    cfgChannel = '0;
    cfgDivide  = '0;
`ifdef SM_CLK_DIVIDER_SYNC_EN
    syncIn     = 1'b0;
`endif
    modelReset();
    repeat (2) @(negedge clk);
    check("resetClk", {28'b0, clkOut}, 32'd0);
    check("resetTick", {28'b0, tickOut}, 32'd0);
    check("resetReady", {31'b0, cfgReady}, 32'd1);
    rst = 1'b0;

    // Default divide-by-2 on every channel
    idle(8);

    // ch1 to period 5
    writeWait(1, 5);
    idle(20);

    // Back-to-back writes to ch2; second must stall, ch3 still accepted
    writeWait(2, 8);
    drive(1'b1, 1'b1, 2, 3, 1'b0);
    drive(1'b1, 1'b1, 3, 7, 1'b0);
    writeWait(2, 3);
    idle(20);

    // ch0 off, stays off, then back on with period 4
    writeWait(0, 0);
    writeWait(0, 1);
    idle(4);
    writeWait(0, 4);
    idle(12);

    // Freeze mid-period for three cycles
    idle(2);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 0, 0, 1'b0);
    idle(12);

    // Write while frozen: off channel applies anyway, active waits for wrap
    writeWait(0, 0);
    idle(6);
    drive(1'b0, 1'b1, 0, 6, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    idle(14);

    // Reset mid-period with writes pending
    drive(1'b1, 1'b1, 1, 9, 1'b0);
    drive(1'b1, 1'b1, 2, 9, 1'b0);
    midReset();
    idle(6);

`ifdef SM_CLK_DIVIDER_SYNC_EN
    // Program 3/4/6/8 and align all channels with one sync pulse
    writeWait(0, 3);
    writeWait(1, 4);
    writeWait(2, 6);
    writeWait(3, 8);
    drive(1'b1, 1'b0, 0, 0, 1'b1);
    idle(50);
    // Sync while frozen is ignored
    drive(1'b0, 1'b0, 0, 0, 1'b1);
    idle(5);
`endif

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      en  = ($urandom_range(0, 9) != 0);
      v   = ($urandom_range(0, 3) == 0);
      ch  = $urandom_range(0, CH - 1);
      div = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 9);
      sy  = 1'b0;
`ifdef SM_CLK_DIVIDER_SYNC_EN
      sy  = ($urandom_range(0, 39) == 0);
`endif
      if (k == 1500) begin
        midReset();
      end
      drive(en, v, ch, div, sy);
    end

    @(posedge clk);
    #3;
    check("drained", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
